spi_slave_bmm150: RTL and testbench

// - SPI responder emulating the BMM150 register interface (mode 3: SCLK idles high; MOSI sampled on rising edge; MISO launched after falling edge).
// - Serves our BMM150 SPI master in simulation and in FPGA loopback without the sensor attached.
// - Holds a 0x40..0x71 register file. The sensor-side update port loads the read-only data/status registers.

---
 rtl/bmm150_pkg.sv | 36 +++
 rtl/bmm150_spi_sync.sv | 46 ++++
 rtl/spi_slave_bmm150.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_bmm150.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmm150_pkg.sv
// rtl/bmm150_pkg.sv - shared BMM150 register map constants, FSM state type and address helpers
package bmm150_pkg;

    localparam logic [6:0] CHIP_ID_ADDR = 7'h40;
    localparam logic [6:0] DATA_LO      = 7'h42;
    localparam logic [6:0] DATA_HI      = 7'h4A;
    localparam logic [6:0] PWR_CTRL     = 7'h4B;
    localparam logic [6:0] REG_LAST     = 7'h71;

    localparam logic [7:0] PWR_CTRL_RST = 8'h01;

    // Bit position of the read/write flag inside the command byte (1 = read)
    localparam int RW_BIT = 7;

    // Number of implemented registers, CHIP_ID_ADDR..REG_LAST inclusive
    localparam int REG_COUNT = 50;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } state_t;

    function automatic logic in_map(input logic [6:0] a);
        return (a >= CHIP_ID_ADDR) && (a <= REG_LAST);
    endfunction

    // Register file index for an address already known to be in the map
    function automatic logic [5:0] reg_idx(input logic [6:0] a);
        logic [6:0] d;
        d = a - CHIP_ID_ADDR;
        return d[5:0];
    endfunction

endpackage

// File: rtl/bmm150_spi_sync.sv
// rtl/bmm150_spi_sync.sv - 2-FF synchronizers for SPI pins with SCLK and CS edge pulses
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, mosi, cs_n      raw SPI pins from the master (asynchronous)
//   mosi_s                synchronized MOSI, aligned with sclk_rise
//   sclk_rise, sclk_fall  1-cycle pulses on synchronized SCLK edges
//   cs_fall, cs_rise      1-cycle pulses on synchronized cs_n edges
module bmm150_spi_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    // [0],[1] are the synchronizer stages, [2] is the previous synced value
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // SCLK and cs_n reset to their idle-high levels so no edge is seen on reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b111;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign mosi_s    = mosi_q[1];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
    assign cs_fall   = ~cs_q[1]   &  cs_q[2];
    assign cs_rise   =  cs_q[1]   & ~cs_q[2];

endmodule

// File: rtl/spi_slave_bmm150.sv
// rtl/spi_slave_bmm150.sv - SPI mode-3 responder emulating the BMM150 register interface
//
// Optional feature macro: SPI_SLV_BURST_EN (address auto-increment per data byte).
//
// Parameters:
//   CLK_HZ    system clock frequency; must be at least 8x the SCLK rate
//   CHIP_ID   value returned at address 0x40
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   enable                0: frames ignored, miso_oe low
//   sclk, mosi, cs_n      SPI pins from master (asynchronous)
//   miso, miso_oe         SPI data to master and its output enable
//   upd_valid/addr/data   sensor-side load of read-only registers 0x42..0x4A
//   wr_strobe/addr/data   1-cycle pulse reporting a committed SPI write
//   frame_err             1-cycle pulse when a frame ends mid-byte
module spi_slave_bmm150
    import bmm150_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter logic [7:0]  CHIP_ID = 8'h32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    output logic       miso_oe,
    input  logic       upd_valid,
    input  logic [6:0] upd_addr,
    input  logic [7:0] upd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    if (CLK_HZ < 1_000) begin : g_clk_check
        $error("spi_slave_bmm150: CLK_HZ unrealistically low");
    end

    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    bmm150_spi_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    state_t     state;
    logic [4:0] bit_cnt;   // rising edges seen in this frame
    logic [6:0] rx_sr;     // last 7 MOSI bits; completed byte is {rx_sr, mosi_s}
    logic [7:0] tx_sr;
    logic [6:0] addr;
    logic [7:0] regs [REG_COUNT];

    logic [7:0] rx_byte;
    logic [7:0] rd_cmd;
    logic       data_done;

    assign rx_byte = {rx_sr, mosi_s};

    // Value for the address in the byte completing on this rise; regs are read
    // before any same-cycle update lands, so a colliding upd_valid yields the old value.
    assign rd_cmd = in_map(rx_byte[6:0]) ? regs[reg_idx(rx_byte[6:0])] : 8'h00;

`ifdef SPI_SLV_BURST_EN
    logic [6:0] addr_next;
    logic [7:0] rd_next;
    assign addr_next = addr + 7'd1;
    assign rd_next   = in_map(addr_next) ? regs[reg_idx(addr_next)] : 8'h00;
    assign data_done = 1'b0;
`else
    // bit_cnt parks at 16 after the single data byte; further SCLK activity is ignored
    assign data_done = bit_cnt[4];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            addr      <= '0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 8'h00;
            end
            regs[reg_idx(CHIP_ID_ADDR)] <= CHIP_ID;
            regs[reg_idx(PWR_CTRL)]     <= PWR_CTRL_RST;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            // Sensor-side loads only touch 0x42..0x4A, which SPI writes never reach
            if (upd_valid && (upd_addr >= DATA_LO) && (upd_addr <= DATA_HI)) begin
                regs[reg_idx(upd_addr)] <= upd_data;
            end

            // Dropping enable mid-frame is treated exactly like cs_n rising
            if ((state != IDLE) && (cs_rise || !enable)) begin
                frame_err <= (bit_cnt[2:0] != 3'd0);
                state     <= IDLE;
                bit_cnt   <= '0;
                miso_oe   <= 1'b0;
                miso      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        miso_oe <= 1'b0;
                        miso    <= 1'b1;
                        if (cs_fall && enable) begin
                            state <= CMD;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                addr <= rx_byte[6:0];
                                if (rx_byte[RW_BIT]) begin
                                    state   <= RDATA;
                                    tx_sr   <= rd_cmd;
                                    miso_oe <= 1'b1;
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end

                    WDATA: begin
                        if (sclk_rise && !data_done) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt[2:0] == 3'd7) begin
                                if ((addr >= PWR_CTRL) && (addr <= REG_LAST)) begin
                                    regs[reg_idx(addr)] <= rx_byte;
                                    wr_strobe           <= 1'b1;
                                    wr_addr             <= addr;
                                    wr_data             <= rx_byte;
                                end
`ifdef SPI_SLV_BURST_EN
                                addr    <= addr_next;
                                bit_cnt <= 5'd8;
`endif
                            end
                        end
                    end

                    RDATA: begin
                        if (sclk_fall && !data_done) begin
                            miso  <= tx_sr[7];
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                        if (sclk_rise && !data_done) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt[2:0] == 3'd7) begin
`ifdef SPI_SLV_BURST_EN
                                tx_sr   <= rd_next;
                                addr    <= addr_next;
                                bit_cnt <= 5'd8;
`else
                                miso_oe <= 1'b0;
                                miso    <= 1'b1;
`endif
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_bmm150.sv
// tb/tb_spi_slave_bmm150.sv - self-checking bench for spi_slave_bmm150 with a register-map reference model
module tb_spi_slave_bmm150;

`ifdef SPI_SLV_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       sclk = 1'b1;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic       miso_oe;
    logic       upd_valid = 1'b0;
    logic [6:0] upd_addr = '0;
    logic [7:0] upd_data = '0;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    int checks = 0;
    int fails = 0;

    int         strobe_cnt = 0;
    int         ferr_cnt = 0;
    logic [6:0] last_wa = '0;
    logic [7:0] last_wd = '0;

    // Reference register map indexed by full 7-bit address
    logic [7:0] mdl [128];

    spi_slave_bmm150 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .upd_valid (upd_valid),
        .upd_addr  (upd_addr),
        .upd_data  (upd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    function automatic void mdl_reset();
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        mdl[8'h40] = 8'h32;
        mdl[8'h4B] = 8'h01;
    endfunction

    function automatic logic [7:0] mdl_read(input logic [6:0] a);
        return (a >= 7'h40 && a <= 7'h71) ? mdl[a] : 8'h00;
    endfunction

    function automatic bit writable(input logic [6:0] a);
        return a >= 7'h4B && a <= 7'h71;
    endfunction

    function automatic bit updatable(input logic [6:0] a);
        return a >= 7'h42 && a <= 7'h4A;
    endfunction

    // Expected miso_oe seen just before each rising edge: high only in data bytes of a read
    function automatic logic [31:0] exp_oe(input bit rd, input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++)
            if (rd && i >= 8 && (BURST || i < 16)) m[31-i] = 1'b1;
        return m;
    endfunction

    // One mode-3 frame; bit i is driven after fall i and sampled just before rise i.
    task automatic spi_xfer(input logic [31:0] tx, input int nbits, input bit drop_en,
                            input int upd_bit, output logic [31:0] rx, output logic [31:0] oe);
        rx = '1;
        oe = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = tx[31-i];
            repeat (5) @(negedge clk);
            rx[31-i] = miso;
            oe[31-i] = miso_oe;
            sclk = 1'b1;
            if (i == upd_bit) begin
                repeat (2) @(negedge clk);
                upd_valid = 1'b1;
                @(negedge clk);
                upd_valid = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
        end
        if (drop_en) begin
            enable = 1'b0;
            repeat (6) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_upd(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        upd_addr = a;
        upd_data = d;
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        if (updatable(a)) mdl[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b1) begin fails++; $display("FAIL reset_miso: got %b expected 1", miso); end
        checks++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        checks++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if (wr_addr !== 7'h00) begin fails++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        mdl_reset();
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_chip_id();
        logic [31:0] rx, oe;
        spi_xfer({8'hC0, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== 8'h32) begin fails++; $display("FAIL chip_id: got %h expected 32", rx[23:16]); end
        checks++; if (oe !== exp_oe(1'b1, 16)) begin fails++; $display("FAIL chip_id_oe: got %h expected %h", oe, exp_oe(1'b1, 16)); end
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b1) begin fails++; $display("FAIL idle_after_read: got oe=%b miso=%b expected oe=0 miso=1", miso_oe, miso); end
    endtask

    task automatic test_write_read();
        logic [31:0] rx, oe;
        int s0;
        s0 = strobe_cnt;
        spi_xfer({8'h4C, 8'hA5, 16'h0}, 16, 1'b0, -1, rx, oe);
        mdl[8'h4C] = 8'hA5;
        checks++; if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL write_strobe_count: got %0d expected 1", strobe_cnt - s0); end
        checks++; if (last_wa !== 7'h4C || last_wd !== 8'hA5) begin fails++; $display("FAIL write_strobe_fields: got %h/%h expected 4c/a5", last_wa, last_wd); end
        checks++; if (oe !== 32'h0) begin fails++; $display("FAIL write_oe: got %h expected 0", oe); end
        spi_xfer({8'hCC, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== mdl_read(7'h4C)) begin fails++; $display("FAIL readback_4c: got %h expected %h", rx[23:16], mdl_read(7'h4C)); end
    endtask

    task automatic test_readonly_update();
        logic [31:0] rx, oe;
        int s0;
        s0 = strobe_cnt;
        spi_xfer({8'h42, 8'h77, 16'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (strobe_cnt !== s0) begin fails++; $display("FAIL ro_write_strobe: got %0d expected 0", strobe_cnt - s0); end
        do_upd(7'h42, 8'h5A);
        do_upd(7'h4C, 8'hEE);
        spi_xfer({8'hC2, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== 8'h5A) begin fails++; $display("FAIL upd_read_42: got %h expected 5a", rx[23:16]); end
        spi_xfer({8'hCC, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== mdl_read(7'h4C)) begin fails++; $display("FAIL upd_ignored_4c: got %h expected %h", rx[23:16], mdl_read(7'h4C)); end
    endtask

    task automatic test_frame_error();
        logic [31:0] rx, oe;
        int s0, f0;
        s0 = strobe_cnt; f0 = ferr_cnt;
        spi_xfer({8'h4C, 8'h3C, 16'h0}, 11, 1'b0, -1, rx, oe);
        checks++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_11bits: got %0d pulses expected 1", ferr_cnt - f0); end
        checks++; if (strobe_cnt !== s0) begin fails++; $display("FAIL ferr_no_commit: got %0d strobes expected 0", strobe_cnt - s0); end
        f0 = ferr_cnt;
        spi_xfer({8'hCC, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== mdl_read(7'h4C)) begin fails++; $display("FAIL ferr_reg_unchanged: got %h expected %h", rx[23:16], mdl_read(7'h4C)); end
        spi_xfer({8'h4D, 24'h0}, 8, 1'b0, -1, rx, oe);
        checks++; if (ferr_cnt !== f0) begin fails++; $display("FAIL cmd_only_silent: got %0d pulses expected 0", ferr_cnt - f0); end
        spi_xfer({8'hC0, 24'h0}, 3, 1'b1, -1, rx, oe);
        checks++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL enable_drop_ferr: got %0d pulses expected 1", ferr_cnt - f0); end
        spi_xfer({8'hC0, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== 8'h32) begin fails++; $display("FAIL after_enable_drop: got %h expected 32", rx[23:16]); end
    endtask

    task automatic test_update_collision();
        logic [31:0] rx, oe;
        logic [7:0] old;
        old = mdl_read(7'h43);
        upd_addr = 7'h43;
        upd_data = old ^ 8'hC3;
        spi_xfer({8'hC3, 24'h0}, 16, 1'b0, 7, rx, oe);
        checks++; if (rx[23:16] !== old) begin fails++; $display("FAIL collision_old_value: got %h expected %h", rx[23:16], old); end
        mdl[8'h43] = old ^ 8'hC3;
        spi_xfer({8'hC3, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== mdl_read(7'h43)) begin fails++; $display("FAIL collision_new_value: got %h expected %h", rx[23:16], mdl_read(7'h43)); end
    endtask

    task automatic test_burst_read();
        logic [31:0] rx, oe;
        do_upd(7'h42, 8'h11);
        do_upd(7'h43, 8'h22);
        do_upd(7'h44, 8'h33);
        spi_xfer({8'hC2, 24'h0}, 32, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== 8'h11) begin fails++; $display("FAIL burst_byte0: got %h expected 11", rx[23:16]); end
        checks++; if (oe !== exp_oe(1'b1, 32)) begin fails++; $display("FAIL burst_oe: got %h expected %h", oe, exp_oe(1'b1, 32)); end
        if (BURST) begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (rx[23-8*k -: 8] !== mdl_read(7'(8'h42 + k))) begin
                    fails++;
                    $display("FAIL burst_byte%0d: got %h expected %h", k, rx[23-8*k -: 8], mdl_read(7'(8'h42 + k)));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rx, oe;
        logic [6:0] a;
        logic [7:0] d;
        int op, s0;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 2);
            a = 7'($urandom_range(8'h38, 8'h7F));
            d = 8'($urandom);
            if (op == 0) begin
                do_upd(a, d);
            end else if (op == 1) begin
                s0 = strobe_cnt;
                spi_xfer({1'b0, a, d, 16'h0}, 16, 1'b0, -1, rx, oe);
                checks++;
                if (strobe_cnt - s0 !== int'(writable(a))) begin
                    fails++; $display("FAIL rand_write_strobe a=%h: got %0d expected %0d", a, strobe_cnt - s0, writable(a));
                end else if (writable(a)) begin
                    checks++;
                    if (last_wa !== a || last_wd !== d) begin
                        fails++; $display("FAIL rand_write_fields: got %h/%h expected %h/%h", last_wa, last_wd, a, d);
                    end
                end
                if (writable(a)) mdl[a] = d;
            end else begin
                spi_xfer({1'b1, a, 24'h0}, 16, 1'b0, -1, rx, oe);
                checks++;
                if (rx[23:16] !== mdl_read(a) || oe !== exp_oe(1'b1, 16)) begin
                    fails++; $display("FAIL rand_read a=%h: got %h oe=%h expected %h oe=%h", a, rx[23:16], oe, mdl_read(a), exp_oe(1'b1, 16));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx, oe;
        logic [7:0] cmd;
        spi_xfer({8'h50, 8'h99, 16'h0}, 16, 1'b0, -1, rx, oe);
        cmd = 8'hC0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            sclk = 1'b0;
            mosi = (i < 8) ? cmd[7-i] : 1'b0;
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
        checks++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL midframe_oe_before_reset: got %b expected 1", miso_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b1) begin fails++; $display("FAIL async_reset_outputs: got oe=%b miso=%b expected oe=0 miso=1", miso_oe, miso); end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        repeat (4) @(negedge clk);
        spi_xfer({8'hD0, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== mdl_read(7'h50)) begin fails++; $display("FAIL reset_reverts_50: got %h expected %h", rx[23:16], mdl_read(7'h50)); end
        spi_xfer({8'hCB, 24'h0}, 16, 1'b0, -1, rx, oe);
        checks++; if (rx[23:16] !== 8'h01) begin fails++; $display("FAIL reset_pwr_ctrl: got %h expected 01", rx[23:16]); end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_read_chip_id();
        test_write_read();
        test_readonly_update();
        test_frame_error();
        test_update_collision();
        test_burst_read();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
